// File: rtl/nn_config_loader.sv
// Word-stream to daisy-chain configuration serialiser.
// One command selects a chain and a bit count; words are shifted out MSB first under a divided data_clk.
module nn_config_loader #(
  parameter int NUM_CHAINS = 2,
  parameter int CHAIN_W    = 1,
  parameter int WORD_W     = 16,
  parameter int LEN_W      = 16,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CHAIN_W-1:0]    cmd_chain,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [WORD_W-1:0]     data_word,
  output logic [NUM_CHAINS-1:0] cfg_data_clk,
  output logic [NUM_CHAINS-1:0] cfg_data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]   WORD_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CHAIN_W:0]   NC        = (CHAIN_W + 1)'(NUM_CHAINS);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, HIGH, FIN} state_t;

  state_t                  state, state_nx;
  logic [CHAIN_W-1:0]      chain_q, chain_nx;
  logic [LEN_W-1:0]        rem, rem_nx;
  logic [WORD_W-1:0]       sreg, sreg_nx;
  logic [IDX_W-1:0]        bit_idx, idx_nx;
  logic [DIV_W-1:0]        div_cnt, div_nx;
  logic [NUM_CHAINS-1:0]   sel_nx, clk_nx, din_nx;
  logic                    err_nx, cmd_bad;

  assign cmd_bad = ({1'b0, cmd_chain} >= NC) || (cmd_len == '0);

  always_comb begin
    state_nx = state;
    chain_nx = chain_q;
    rem_nx   = rem;
    sreg_nx  = sreg;
    idx_nx   = bit_idx;
    div_nx   = div_cnt;
    err_nx   = 1'b0;
    din_nx   = cfg_data_in;
    case (state)
      IDLE: if (cmd_valid && cmd_ready) begin
        if (cmd_bad) err_nx = 1'b1;
        else begin
          chain_nx = cmd_chain;
          rem_nx   = cmd_len;
          idx_nx   = '0;
          state_nx = LOAD;
        end
      end
      LOAD: if (data_valid && data_ready) begin
        sreg_nx  = data_word;
        div_nx   = '0;
        state_nx = SETUP;
      end
      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          div_nx   = '0;
          state_nx = HIGH;
        end else div_nx = div_cnt + DIV_W'(1);
      end
      HIGH: begin
        if (div_cnt == DIV_LAST) begin
          div_nx  = '0;
          rem_nx  = rem - LEN_W'(1);
          sreg_nx = sreg << 1;
          if (rem == LEN_W'(1)) state_nx = FIN;
          else if (bit_idx == WORD_LAST) begin
            idx_nx   = '0;
            state_nx = LOAD;
          end else begin
            idx_nx   = bit_idx + IDX_W'(1);
            state_nx = SETUP;
          end
        end else div_nx = div_cnt + DIV_W'(1);
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it cycle-for-cycle.
    sel_nx = NUM_CHAINS'(1) << chain_nx;
    clk_nx = (state_nx == HIGH) ? sel_nx : '0;
    if (state_nx == SETUP)    din_nx = sel_nx & {NUM_CHAINS{sreg_nx[WORD_W-1]}};
    else if (state_nx == FIN) din_nx = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      chain_q      <= '0;
      rem          <= '0;
      sreg         <= '0;
      bit_idx      <= '0;
      div_cnt      <= '0;
      cmd_ready    <= 1'b1;
      data_ready   <= 1'b0;
      cfg_data_clk <= '0;
      cfg_data_in  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nx;
      chain_q      <= chain_nx;
      rem          <= rem_nx;
      sreg         <= sreg_nx;
      bit_idx      <= idx_nx;
      div_cnt      <= div_nx;
      cmd_ready    <= (state_nx == IDLE);
      data_ready   <= (state_nx == LOAD);
      cfg_data_clk <= clk_nx;
      cfg_data_in  <= din_nx;
      busy         <= (state_nx != IDLE);
      done         <= (state_nx == FIN);
      err          <= err_nx;
    end
  end

endmodule

// File: tb/tb_nn_config_loader.sv
// Bench for nn_config_loader: dut0 (CLK_DIV=2) carries most scenarios, dut1 (CLK_DIV=1) the fast-divider case.
// Expected bits come from slicing the host words MSB first; expected timing from the per-bit cost of 2*CLK_DIV.
module tb_nn_config_loader;
  localparam int NC = 2, CW = 2, WW = 8, LW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cmd_valid [2], cmd_ready [2], data_valid [2], data_ready [2];
  logic          busy [2], done [2], err [2];
  logic [CW-1:0] cmd_chain [2];
  logic [LW-1:0] cmd_len [2];
  logic [WW-1:0] data_word [2];
  logic [NC-1:0] cfg_clk [2], cfg_in [2];

  nn_config_loader #(.NUM_CHAINS(NC), .CHAIN_W(CW), .WORD_W(WW), .LEN_W(LW), .CLK_DIV(2)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_chain(cmd_chain[0]), .cmd_len(cmd_len[0]), .data_valid(data_valid[0]),
    .data_ready(data_ready[0]), .data_word(data_word[0]), .cfg_data_clk(cfg_clk[0]),
    .cfg_data_in(cfg_in[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

  nn_config_loader #(.NUM_CHAINS(NC), .CHAIN_W(CW), .WORD_W(WW), .LEN_W(LW), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_chain(cmd_chain[1]), .cmd_len(cmd_len[1]), .data_valid(data_valid[1]),
    .data_ready(data_ready[1]), .data_word(data_word[1]), .cfg_data_clk(cfg_clk[1]),
    .cfg_data_in(cfg_in[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  // dut0 observer: logs each rising data_clk edge with its sampled bit and cycle.
  logic          bits_q [NC][$];
  int            ecyc_q [NC][$];
  int            act [NC];
  logic [NC-1:0] prev_clk = '0;
  logic          prev_busy = 1'b0;
  int            done_cnt = 0, done_cyc = -1, err_cnt = 0, dr_cnt = 0, busy_fall = -1;

  initial for (int c = 0; c < NC; c++) act[c] = 0;

  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (cfg_clk[0][c] && !prev_clk[c]) begin
        bits_q[c].push_back(cfg_in[0][c]);
        ecyc_q[c].push_back(cyc);
      end
      if (cfg_clk[0][c] || cfg_in[0][c]) act[c] <= act[c] + 1;
    end
    prev_clk <= cfg_clk[0];
    if (done[0]) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (err[0]) err_cnt <= err_cnt + 1;
    if (data_ready[0]) dr_cnt <= dr_cnt + 1;
    if (prev_busy && !busy[0]) busy_fall <= cyc;
    prev_busy <= busy[0];
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the handshake cycle.
  task automatic send_cmd(input int u, input int ch, input int len, input bit hold, output int hs);
    cmd_valid[u] = 1'b1; cmd_chain[u] = CW'(ch); cmd_len[u] = LW'(len); hs = -1;
    for (int t = 0; t < 400; t++) begin
      if (cmd_ready[u]) begin
        hs = cyc;
        @(negedge clk);
        if (!hold) cmd_valid[u] = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (hs < 0) begin errors++; $display("FAIL cmd_handshake got timeout exp accept"); end
  endtask

  // Waits for data_ready, idles gap cycles, then offers the word.
  task automatic send_data(input int u, input logic [WW-1:0] w, input int gap, output int hs);
    hs = -1;
    for (int t = 0; t < 400 && !data_ready[u]; t++) @(negedge clk);
    repeat (gap) @(negedge clk);
    data_valid[u] = 1'b1; data_word[u] = w;
    for (int t = 0; t < 400; t++) begin
      if (data_ready[u]) begin
        hs = cyc;
        @(negedge clk);
        data_valid[u] = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (hs < 0) begin errors++; $display("FAIL data_handshake got timeout exp accept"); end
  endtask

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      if (done[0]) begin to = 1'b0; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({cmd_ready[u], data_ready[u], busy[u], done[u], err[u], cfg_clk[u], cfg_in[u]} !== 9'h100) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got %b exp 100000000", u,
                 {cmd_ready[u], data_ready[u], busy[u], done[u], err[u], cfg_clk[u], cfg_in[u]});
      end
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready[0], busy[0], cfg_clk[0], cfg_in[0]} !== 6'b100000) begin
      errors++; $display("FAIL idle_after_release got %b exp 100000", {cmd_ready[0], busy[0], cfg_clk[0], cfg_in[0]});
    end
  endtask

  task automatic test_single();
    int hs, w, b0, a0, bad; bit to; logic [7:0] obs;
    b0 = bits_q[1].size(); a0 = act[0]; bad = 0; obs = '0;
    send_cmd(0, 1, 8, 0, hs);
    send_data(0, 8'hA5, 0, w);
    wait_done(to);
    checks++;
    if (to || bits_q[1].size() - b0 != 8) begin
      errors++; $display("FAIL single_edges got %0d exp 8 (timeout %0d)", bits_q[1].size() - b0, to);
    end
    for (int k = 0; k < 8; k++) begin
      obs[7-k] = bits_q[1][b0+k];
      if (ecyc_q[1][b0+k] != w + 3 + 4*k) bad++;
    end
    checks++;
    if (obs !== 8'b10100101) begin errors++; $display("FAIL single_bits got %b exp 10100101", obs); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_edge_timing got %0d late edges exp 0", bad); end
    checks++;
    if (done_cyc != w + 33) begin errors++; $display("FAIL single_done got %0d exp %0d", done_cyc, w + 33); end
    checks++;
    if (busy_fall != w + 34) begin errors++; $display("FAIL single_busy_fall got %0d exp %0d", busy_fall, w + 34); end
    checks++;
    if (act[0] != a0) begin errors++; $display("FAIL single_idle_chain got %0d exp %0d", act[0], a0); end
  endtask

  task automatic test_stall();
    int hs, w1, w2, b0, a0; bit to; logic [11:0] obs;
    b0 = bits_q[0].size(); a0 = act[1]; obs = '0;
    send_cmd(0, 0, 12, 0, hs);
    send_data(0, 8'h12, 0, w1);
    send_data(0, 8'h3F, 5, w2);
    wait_done(to);
    checks++;
    if (to || bits_q[0].size() - b0 != 12) begin
      errors++; $display("FAIL stall_edges got %0d exp 12", bits_q[0].size() - b0);
    end
    for (int k = 0; k < 12; k++) obs[11-k] = bits_q[0][b0+k];
    checks++;
    if (obs !== 12'b0001_0010_0011) begin errors++; $display("FAIL stall_bits got %b exp 000100100011", obs); end
    checks++;
    if (ecyc_q[0][b0+8] != w2 + 3 || ecyc_q[0][b0+7] != w1 + 31) begin
      errors++; $display("FAIL stall_gap_edges got %0d/%0d exp %0d/%0d",
                         ecyc_q[0][b0+7], ecyc_q[0][b0+8], w1 + 31, w2 + 3);
    end
    checks++;
    if (done_cyc != w2 + 17) begin errors++; $display("FAIL stall_done got %0d exp %0d", done_cyc, w2 + 17); end
    checks++;
    if (act[1] != a0) begin errors++; $display("FAIL stall_idle_chain got %0d exp %0d", act[1], a0); end
  endtask

  task automatic test_reject();
    int hs, d0, e0, a0, a1, n0;
    for (int r = 0; r < 2; r++) begin
      d0 = dr_cnt; e0 = err_cnt; a0 = act[0]; a1 = act[1]; n0 = done_cnt;
      if (r == 0) send_cmd(0, 2, 4, 0, hs);
      else        send_cmd(0, 1, 0, 0, hs);
      checks++;
      if (err[0] !== 1'b1 || cmd_ready[0] !== 1'b1) begin
        errors++; $display("FAIL reject%0d_err got err=%b rdy=%b exp 1/1", r, err[0], cmd_ready[0]);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (err_cnt - e0 != 1 || dr_cnt != d0 || act[0] != a0 || act[1] != a1 || done_cnt != n0 || busy[0] !== 1'b0) begin
        errors++; $display("FAIL reject%0d_quiet got errs=%0d ready=%0d act=%0d/%0d exp 1/0/0/0",
                           r, err_cnt - e0, dr_cnt - d0, act[0] - a0, act[1] - a1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int hs, w, b0, n0; bit to; logic [7:0] obs;
    b0 = bits_q[1].size(); n0 = done_cnt; obs = '0;
    send_cmd(0, 1, 16, 0, hs);
    send_data(0, 8'h5A, 0, w);
    for (int t = 0; t < 200 && bits_q[1].size() < b0 + 5; t++) @(negedge clk);
    checks++;
    if (cfg_clk[0][1] !== 1'b1) begin errors++; $display("FAIL midreset_in_high got %b exp 1", cfg_clk[0][1]); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({cfg_clk[0], cfg_in[0], busy[0], cmd_ready[0]} !== 6'b000001) begin
      errors++; $display("FAIL midreset_async got %b exp 000001", {cfg_clk[0], cfg_in[0], busy[0], cmd_ready[0]});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != n0 || bits_q[1].size() != b0 + 5) begin
      errors++; $display("FAIL midreset_abandon got done=%0d edges=%0d exp 0/5", done_cnt - n0, bits_q[1].size() - b0);
    end
    b0 = bits_q[0].size();
    send_cmd(0, 0, 8, 0, hs);
    send_data(0, 8'hFF, 0, w);
    wait_done(to);
    for (int k = 0; k < 8; k++) obs[k] = bits_q[0][b0+k];
    checks++;
    if (to || bits_q[0].size() - b0 != 8 || obs !== 8'hFF) begin
      errors++; $display("FAIL midreset_recover got %b (%0d edges) exp 11111111", obs, bits_q[0].size() - b0);
    end
  endtask

  task automatic test_back_to_back();
    int h1, h2, w1, w2, b0, b1; bit to; logic [2:0] o0; logic [1:0] o1;
    b0 = bits_q[0].size(); b1 = bits_q[1].size();
    send_cmd(0, 0, 3, 1, h1);
    send_data(0, 8'hE0, 0, w1);
    send_cmd(0, 1, 2, 0, h2);
    checks++;
    if (done_cyc != w1 + 13 || h2 != w1 + 14) begin
      errors++; $display("FAIL b2b_handshake got done=%0d hs=%0d exp %0d/%0d", done_cyc, h2, w1 + 13, w1 + 14);
    end
    send_data(0, 8'h40, 0, w2);
    wait_done(to);
    for (int k = 0; k < 3; k++) o0[2-k] = bits_q[0][b0+k];
    for (int k = 0; k < 2; k++) o1[1-k] = bits_q[1][b1+k];
    checks++;
    if (to || bits_q[0].size() - b0 != 3 || o0 !== 3'b111) begin
      errors++; $display("FAIL b2b_chain0 got %b exp 111", o0);
    end
    checks++;
    if (bits_q[1].size() - b1 != 2 || o1 !== 2'b01 || ecyc_q[1][b1] != w2 + 3) begin
      errors++; $display("FAIL b2b_chain1 got %b first edge %0d exp 01 at %0d", o1, ecyc_q[1][b1], w2 + 3);
    end
  endtask

  task automatic test_div1();
    int hs, w, ne, ecy, dcy, other; logic prev, ebit;
    prev = 1'b0; ne = 0; ecy = -1; dcy = -1; other = 0; ebit = 1'b0;
    send_cmd(1, 0, 1, 0, hs);
    send_data(1, 8'h80, 0, w);
    for (int t = 0; t < 6; t++) begin
      if (cfg_clk[1][0] && !prev) begin ne++; ecy = cyc; ebit = cfg_in[1][0]; end
      prev = cfg_clk[1][0];
      if (done[1]) dcy = cyc;
      if (cfg_clk[1][1] || cfg_in[1][1] || err[1]) other++;
      @(negedge clk);
    end
    checks++;
    if (ne != 1 || ecy != w + 2 || ebit !== 1'b1) begin
      errors++; $display("FAIL div1_edge got n=%0d at %0d bit %b exp 1 at %0d bit 1", ne, ecy, ebit, w + 2);
    end
    checks++;
    if (dcy != w + 3 || other != 0 || busy[1] !== 1'b0) begin
      errors++; $display("FAIL div1_done got %0d other=%0d exp %0d other=0", dcy, other, w + 3);
    end
  endtask

  task automatic test_random();
    int ch, len, nw, hs, w, b0, a0, bad, e0; bit to;
    logic [7:0] ws[$]; int hsw[$]; logic [31:0] obs, expv;
    for (int it = 0; it < 12; it++) begin
      ch = $urandom_range(0, 1); len = $urandom_range(1, 20);
      if ($urandom_range(0, 3) == 0) begin
        e0 = err_cnt;
        if ($urandom_range(0, 1) == 1) send_cmd(0, $urandom_range(2, 3), $urandom_range(1, 20), 0, hs);
        else                           send_cmd(0, ch, 0, 0, hs);
        checks++;
        if (err[0] !== 1'b1) begin errors++; $display("FAIL rand%0d_reject got %b exp 1", it, err[0]); end
        @(negedge clk);
      end
      ws.delete(); hsw.delete();
      nw = (len + 7) / 8;
      for (int j = 0; j < nw; j++) ws.push_back(8'($urandom));
      b0 = bits_q[ch].size(); a0 = act[1-ch];
      send_cmd(0, ch, len, 0, hs);
      for (int j = 0; j < nw; j++) begin
        send_data(0, ws[j], $urandom_range(0, 4), w);
        hsw.push_back(w);
      end
      wait_done(to);
      obs = '0; expv = '0; bad = 0;
      for (int k = 0; k < len; k++) begin
        expv[k] = ws[k/8][7 - (k % 8)];
        obs[k]  = bits_q[ch][b0+k];
        if (ecyc_q[ch][b0+k] != hsw[k/8] + 3 + 4*(k % 8)) bad++;
      end
      checks++;
      if (to || bits_q[ch].size() - b0 != len || obs !== expv) begin
        errors++; $display("FAIL rand%0d_bits ch%0d len%0d got %h (%0d edges) exp %h",
                           it, ch, len, obs, bits_q[ch].size() - b0, expv);
      end
      checks++;
      if (bad != 0 || done_cyc != hsw[nw-1] + 4*(len - 8*(nw-1)) + 1 || act[1-ch] != a0) begin
        errors++; $display("FAIL rand%0d_timing got late=%0d done=%0d other=%0d exp 0/%0d/0",
                           it, bad, done_cyc, act[1-ch] - a0, hsw[nw-1] + 4*(len - 8*(nw-1)) + 1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      cmd_valid[u] = 1'b0; cmd_chain[u] = '0; cmd_len[u] = '0;
      data_valid[u] = 1'b0; data_word[u] = '0;
    end
    test_reset();
    test_single();
    test_stall();
    test_reject();
    test_reset_mid();
    test_back_to_back();
    test_div1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
